// File: rtl/pe_link_if.sv
// pe_link_if: four PE source ports sharing one valid/ready injection link, plus status.
interface pe_link_if #(parameter int DATA_W = 32);
  logic [4*DATA_W-1:0] pe_data;
  logic [3:0]          pe_data_valid;
  logic [3:0]          pe_data_ready;
  logic [DATA_W-1:0]   data;
  logic                data_valid;
  logic                data_ready;
  logic [3:0]          grant;
  logic [31:0]         flit_count;
  modport master (
    output pe_data, pe_data_valid, data_ready,
    input  pe_data_ready, data, data_valid, grant, flit_count
  );
  modport slave (
    input  pe_data, pe_data_valid, data_ready,
    output pe_data_ready, data, data_valid, grant, flit_count
  );
endinterface

// File: rtl/pe_link_arbiter.sv
// pe_link_arbiter: round-robin burst arbiter of 4 PE sources onto one registered link stage.
module pe_link_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input logic   clk,
  input logic   rst,
  pe_link_if.slave l
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t     state;
  logic [1:0] rr_ptr, owner, win, sel, idx;
  logic [3:0] beat_cnt, ready;
  logic       win_ok, load_en, accept, owner_valid;
  assign load_en     = !l.data_valid || l.data_ready;
  assign owner_valid = l.pe_data_valid[owner];
  always_comb begin
    win    = rr_ptr;
    win_ok = 1'b0;
    idx    = 2'd0;
    // scan from the far end so the closest valid source to rr_ptr wins last
    for (int i = 3; i >= 0; i--) begin
      idx = rr_ptr + 2'(i);
      if (l.pe_data_valid[idx]) begin
        win    = idx;
        win_ok = 1'b1;
      end
    end
    sel   = state == LOCK ? owner : win;
    ready = (!rst && load_en && (state == LOCK ? owner_valid : win_ok)) ? 4'b0001 << sel : 4'b0000;
  end
  assign accept          = |ready;
  assign l.pe_data_ready = ready;
  assign l.grant         = state == LOCK ? 4'b0001 << owner : 4'b0000;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= 2'd0;
      owner        <= 2'd0;
      beat_cnt     <= 4'd0;
      l.data       <= '0;
      l.data_valid <= 1'b0;
      l.flit_count <= 32'd0;
    end else begin
      if (l.data_valid && l.data_ready) l.flit_count <= l.flit_count + 32'd1;
      if (accept) begin
        l.data       <= l.pe_data[sel*DATA_W +: DATA_W];
        l.data_valid <= 1'b1;
      end else if (l.data_ready) l.data_valid <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (MAX_BURST == 1) rr_ptr <= win + 2'd1;
          else begin
            state    <= LOCK;
            owner    <= win;
            beat_cnt <= 4'd1;
          end
        end
      end else if (!owner_valid || (load_en && beat_cnt + 4'd1 == 4'(MAX_BURST))) begin
        state  <= IDLE;
        rr_ptr <= owner + 2'd1;
      end else if (load_en) beat_cnt <= beat_cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_pe_link_arbiter.sv
// tb_pe_link_arbiter: vector table, corner sequences and random traffic against a burst/round-robin model.
module tb_pe_link_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pe_link_if #(.DATA_W(32)) la ();
  pe_link_if #(.DATA_W(32)) lb ();
  pe_link_arbiter #(.DATA_W(32), .MAX_BURST(4)) dut_a (.clk(clk), .rst(rst), .l(la));
  pe_link_arbiter #(.DATA_W(32), .MAX_BURST(1)) dut_b (.clk(clk), .rst(rst), .l(lb));
  int checks = 0, failures = 0;
  int m_owner[2], m_beats[2], m_ptr[2], m_cnt[2];
  bit m_v[2];
  logic [31:0] m_d[2];
  int bursts[2] = '{4, 1};
  logic [31:0] dqa[$], dqb[$];
  logic [3:0] last_ra;
  typedef struct {
    logic [3:0] v; logic dr; logic [3:0] rdy; logic dv; logic [31:0] d; logic [3:0] g; int cnt;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_owner[n] = -1; m_beats[n] = 0; m_ptr[n] = 0; m_cnt[n] = 0; m_v[n] = 0; m_d[n] = 0;
    end
    dqa.delete();
    dqb.delete();
  endtask
  task automatic drive(input logic [3:0] v, input logic [127:0] pd, input logic dr);
    la.pe_data_valid = v; la.pe_data = pd; la.data_ready = dr;
    lb.pe_data_valid = v; lb.pe_data = pd; lb.data_ready = dr;
  endtask
  task automatic step(input logic [3:0] v, input logic [127:0] pd, input logic dr);
    int take[2];
    string p;
    @(negedge clk);
    drive(v, pd, dr);
    #1;
    for (int n = 0; n < 2; n++) begin
      p = n == 0 ? "a." : "b.";
      take[n] = -1;
      if (!m_v[n] || dr) begin
        if (m_owner[n] < 0) begin
          for (int i = 0; i < 4; i++)
            if (take[n] < 0 && v[(m_ptr[n] + i) % 4]) take[n] = (m_ptr[n] + i) % 4;
        end else if (v[m_owner[n]]) take[n] = m_owner[n];
      end
      chk({p, "ready"}, n == 0 ? 32'(la.pe_data_ready) : 32'(lb.pe_data_ready),
          take[n] < 0 ? 32'd0 : 32'd1 << take[n]);
    end
    last_ra = la.pe_data_ready;
    if (la.data_valid && dr) dqa.push_back(la.data);
    if (lb.data_valid && dr) dqb.push_back(lb.data);
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      p = n == 0 ? "a." : "b.";
      if (m_v[n] && dr) m_cnt[n]++;
      if (take[n] >= 0) begin
        m_d[n] = pd[take[n]*32 +: 32];
        m_v[n] = 1;
      end else if (dr) m_v[n] = 0;
      if (m_owner[n] < 0) begin
        if (take[n] >= 0) begin
          if (bursts[n] == 1) m_ptr[n] = (take[n] + 1) % 4;
          else begin
            m_owner[n] = take[n];
            m_beats[n] = 1;
          end
        end
      end else if (!v[m_owner[n]]) begin
        m_ptr[n] = (m_owner[n] + 1) % 4;
        m_owner[n] = -1;
      end else if (take[n] >= 0) begin
        m_beats[n]++;
        if (m_beats[n] == bursts[n]) begin
          m_ptr[n] = (m_owner[n] + 1) % 4;
          m_owner[n] = -1;
        end
      end
      chk({p, "valid"}, n == 0 ? 32'(la.data_valid) : 32'(lb.data_valid), 32'(m_v[n]));
      if (m_v[n]) chk({p, "data"}, n == 0 ? la.data : lb.data, m_d[n]);
      chk({p, "grant"}, n == 0 ? 32'(la.grant) : 32'(lb.grant),
          m_owner[n] < 0 ? 32'd0 : 32'd1 << m_owner[n]);
      chk({p, "count"}, n == 0 ? la.flit_count : lb.flit_count, 32'(m_cnt[n]));
    end
  endtask
  task automatic rst_mid();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst.data", la.data, 0);
    chk("rst.valid", 32'(la.data_valid), 0);
    chk("rst.ready", 32'(la.pe_data_ready), 0);
    chk("rst.grant", 32'(la.grant), 0);
    chk("rst.count", la.flit_count, 0);
    drive(4'b0000, '0, 1'b1);
    model_reset();
    #1 rst = 1'b0;
  endtask
  initial begin
    logic [127:0] pd;
    int acc;
    drive(4'b1111, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b1);
    model_reset();
    #7;
    chk("init.ready", 32'(la.pe_data_ready), 0);
    chk("init.valid", 32'(la.data_valid), 0);
    chk("init.grant", 32'(la.grant), 0);
    chk("init.count", la.flit_count, 0);
    drive(4'b0000, '0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    // lock port 1, drop it after 2 flits, port 3 follows; then a stall and a burst end
    tbl[0] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 32'h22, 4'b0010, 0};
    tbl[1] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 32'h22, 4'b0010, 1};
    tbl[2] = '{4'b1000, 1'b1, 4'b0000, 1'b0, 32'h22, 4'b0000, 2};
    tbl[3] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 32'h44, 4'b1000, 2};
    tbl[4] = '{4'b1000, 1'b0, 4'b0000, 1'b1, 32'h44, 4'b1000, 2};
    tbl[5] = '{4'b1000, 1'b0, 4'b0000, 1'b1, 32'h44, 4'b1000, 2};
    tbl[6] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 32'h44, 4'b1000, 3};
    tbl[7] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 32'h44, 4'b1000, 4};
    tbl[8] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 32'h44, 4'b0000, 5};
    tbl[9] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 32'h11, 4'b0001, 6};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, {32'h44, 32'h33, 32'h22, 32'h11}, tbl[i].dr);
      chk($sformatf("tbl%0d.ready", i), 32'(last_ra), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d.valid", i), 32'(la.data_valid), 32'(tbl[i].dv));
      chk($sformatf("tbl%0d.data", i), la.data, tbl[i].d);
      chk($sformatf("tbl%0d.grant", i), 32'(la.grant), 32'(tbl[i].g));
      chk($sformatf("tbl%0d.count", i), la.flit_count, 32'(tbl[i].cnt));
    end
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0);
      chk("stall.ready", 32'(last_ra), 0);
      chk("stall.data", la.data, 32'h11);
      chk("stall.count", la.flit_count, 6);
    end
    rst_mid();
    step(4'b1111, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b1);
    chk("post_rst.first", 32'(last_ra), 32'b0001);
    rst_mid();
    for (int s = 0; s < 18; s++) begin
      for (int k = 0; k < 4; k++) pd[k*32 +: 32] = (32'(k) << 28) | 32'(s);
      step(4'b1111, pd, 1'b1);
      if (s == 16) chk("all.count16", la.flit_count, 16);
    end
    chk("all.delivered", dqa.size(), 17);
    for (int i = 0; i < 17 && i < dqa.size(); i++)
      chk($sformatf("all.port%0d", i), 32'(dqa[i][31:28]), 32'((i / 4) % 4));
    rst_mid();
    acc = 0;
    for (int s = 0; s < 30 && dqa.size() < 8; s++) begin
      step(4'b0100, {32'h0, 32'h200 + 32'(acc), 64'h0}, 1'b1);
      if (last_ra[2]) acc++;
    end
    chk("lone.delivered", dqa.size(), 8);
    for (int i = 0; i < 8 && i < dqa.size(); i++) chk($sformatf("lone.flit%0d", i), dqa[i], 32'h200 + 32'(i));
    rst_mid();
    for (int s = 0; s < 8; s++) begin
      step(4'b0011, {64'h0, 32'hB1, 32'hB0}, 1'b1);
      chk("b1.grant", 32'(lb.grant), 0);
    end
    chk("b1.delivered", dqb.size(), 7);
    for (int i = 0; i < dqb.size(); i++) chk($sformatf("b1.flit%0d", i), dqb[i], 32'hB0 + 32'(i % 2));
    rst_mid();
    for (int s = 0; s < 600; s++)
      step(4'($urandom_range(0, 15)), {$urandom(), $urandom(), $urandom(), $urandom()},
           $urandom_range(0, 3) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
